mem_cmd_ctrl: RTL and testbench

MEM_CMD_CTRL -- requirements
Module: mem_cmd_ctrl

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_cmd_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the UART-to-memory command controller.
//
// Contents:
//   state_t       - controller FSM state encoding
//   OPC_WR/OPC_RD - command opcodes carried in the first frame byte
//   RD_TIMEOUT    - cycles allowed in WAIT_RD before the read is abandoned
//   opcode_valid  - recognises a legal opcode byte
//   rx_drop_state - states in which an incoming byte cannot be used
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        WRITE    = 3'd3,
        READ     = 3'd4,
        WAIT_RD  = 3'd5,
        SEND     = 3'd6
    } state_t;

    localparam logic [7:0] OPC_WR     = 8'h57;
    localparam logic [7:0] OPC_RD     = 8'h52;
    localparam int         RD_TIMEOUT = 4;

    function automatic logic opcode_valid(input logic [7:0] op);
        return (op == OPC_WR) || (op == OPC_RD);
    endfunction

    // Bytes arriving while a memory access or a reply is in flight are
    // discarded and reported; the operation itself carries on.
    function automatic logic rx_drop_state(input state_t st);
        logic drop;
        case (st)
            WRITE, READ, WAIT_RD, SEND: drop = 1'b1;
            default:                    drop = 1'b0;
        endcase
        return drop;
    endfunction

endpackage

// File: rtl/mem_cmd_ctrl.sv
// UART byte-stream command controller for a single-port memory.
//
// Frame format: opcode byte, address byte, then (writes only) NBYTES data
// bytes most-significant first. A read returns the addressed word over the
// tx byte stream, most-significant byte first.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   rx_data, rx_valid   - incoming bytes (one-cycle strobe per byte)
//   tx_data, tx_valid,
//   tx_ready            - outgoing bytes, valid/ready handshake
//   write_En, read_En   - one-cycle memory strobes
//   Address, Data_in    - memory address and write data
//   Data_out, Valid_out - memory read data and its valid strobe
//   busy                - high whenever the FSM is not in IDLE
//   err                 - one-cycle pulse on a protocol error or read timeout
//
// All outputs come straight from registers; the combinational process
// computes every register's next value.
module mem_cmd_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 64,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int NBYTES     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  write_En,
    output logic                  read_En,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Data_in,
    input  logic [DATA_WIDTH-1:0] Data_out,
    input  logic                  Valid_out,
    output logic                  busy,
    output logic                  err
);

    localparam int                CNT_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam int                TMO_W     = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RD_TIMEOUT - 1);

    state_t                  state_r,    state_s;
    logic                    is_wr_r,    is_wr_s;
    logic [CNT_W-1:0]        byte_cnt_r, byte_cnt_s;
    logic [TMO_W-1:0]        tmo_cnt_r,  tmo_cnt_s;
    logic [ADDR_WIDTH-1:0]   addr_r,     addr_s;
    logic [DATA_WIDTH-1:0]   data_in_r,  data_in_s;
    logic [DATA_WIDTH-1:0]   word_r,     word_s;
    logic [7:0]              tx_data_r,  tx_data_s;
    logic                    tx_valid_r, tx_valid_s;
    logic                    write_en_r, write_en_s;
    logic                    read_en_r,  read_en_s;
    logic                    busy_r,     busy_s;
    logic                    err_r,      err_s;
    logic                    addr_bad_s;

    // An address byte is out of range when any bit at or above ADDR_WIDTH is set.
    assign addr_bad_s = ((rx_data >> ADDR_WIDTH) != 8'h00);

    // Next-state and next-output computation for the command FSM.
    always_comb begin
        state_s    = state_r;
        is_wr_s    = is_wr_r;
        byte_cnt_s = byte_cnt_r;
        tmo_cnt_s  = tmo_cnt_r;
        addr_s     = addr_r;
        data_in_s  = data_in_r;
        word_s     = word_r;
        tx_data_s  = tx_data_r;
        tx_valid_s = tx_valid_r;
        write_en_s = 1'b0;
        read_en_s  = 1'b0;
        err_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    if (opcode_valid(rx_data)) begin
                        state_s = GET_ADDR;
                        is_wr_s = (rx_data == OPC_WR);
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            GET_ADDR: begin
                if (rx_valid) begin
                    if (addr_bad_s) begin
                        err_s   = 1'b1;
                        state_s = IDLE;
                    end else begin
                        addr_s = ADDR_WIDTH'(rx_data);
                        if (is_wr_r) begin
                            state_s    = GET_DATA;
                            byte_cnt_s = {CNT_W{1'b0}};
                            data_in_s  = {DATA_WIDTH{1'b0}};
                        end else begin
                            // read_En is registered, so it is high exactly
                            // while the FSM sits in READ.
                            state_s   = READ;
                            read_en_s = 1'b1;
                        end
                    end
                end else begin
                    state_s = GET_ADDR;
                end
            end

            GET_DATA: begin
                if (rx_valid) begin
                    data_in_s = (data_in_r << 4'd8) | DATA_WIDTH'(rx_data);
                    if (byte_cnt_r == LAST_BYTE) begin
                        state_s    = WRITE;
                        write_en_s = 1'b1;
                        byte_cnt_s = {CNT_W{1'b0}};
                    end else begin
                        byte_cnt_s = byte_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = GET_DATA;
                end
            end

            WRITE: begin
                state_s = IDLE;
            end

            READ: begin
                state_s   = WAIT_RD;
                tmo_cnt_s = {TMO_W{1'b0}};
            end

            WAIT_RD: begin
                if (Valid_out) begin
                    state_s    = SEND;
                    word_s     = Data_out;
                    tx_data_s  = Data_out[DATA_WIDTH-1 -: 8];
                    tx_valid_s = 1'b1;
                    byte_cnt_s = {CNT_W{1'b0}};
                    tmo_cnt_s  = {TMO_W{1'b0}};
                end else if (tmo_cnt_r == TMO_LAST) begin
                    // Fourth consecutive cycle without read data.
                    state_s   = IDLE;
                    err_s     = 1'b1;
                    tmo_cnt_s = {TMO_W{1'b0}};
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end

            SEND: begin
                if (tx_valid_r && tx_ready) begin
                    if (byte_cnt_r == LAST_BYTE) begin
                        state_s    = IDLE;
                        tx_valid_s = 1'b0;
                        byte_cnt_s = {CNT_W{1'b0}};
                    end else begin
                        // Shift the next byte into the top position; tx_data
                        // only moves on an accepted handshake.
                        byte_cnt_s = byte_cnt_r + CNT_W'(1);
                        word_s     = word_r << 4'd8;
                        tx_data_s  = word_s[DATA_WIDTH-1 -: 8];
                    end
                end else begin
                    state_s = SEND;
                end
            end

            default: begin
                state_s    = IDLE;
                tx_valid_s = 1'b0;
                byte_cnt_s = {CNT_W{1'b0}};
                tmo_cnt_s  = {TMO_W{1'b0}};
            end
        endcase

        if (rx_valid && rx_drop_state(state_r)) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            is_wr_r    <= 1'b0;
            byte_cnt_r <= {CNT_W{1'b0}};
            tmo_cnt_r  <= {TMO_W{1'b0}};
            addr_r     <= {ADDR_WIDTH{1'b0}};
            data_in_r  <= {DATA_WIDTH{1'b0}};
            word_r     <= {DATA_WIDTH{1'b0}};
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            write_en_r <= 1'b0;
            read_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            is_wr_r    <= is_wr_s;
            byte_cnt_r <= byte_cnt_s;
            tmo_cnt_r  <= tmo_cnt_s;
            addr_r     <= addr_s;
            data_in_r  <= data_in_s;
            word_r     <= word_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            write_en_r <= write_en_s;
            read_en_r  <= read_en_s;
            busy_r     <= busy_s;
            err_r      <= err_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign write_En = write_en_r;
    assign read_En  = read_en_r;
    assign Address  = addr_r;
    assign Data_in  = data_in_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Directed, scoreboard-based bench for mem_cmd_ctrl with a small memory model.
module tb_mem_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        write_En;
    logic        read_En;
    logic [5:0]  Address;
    logic [31:0] Data_in;
    logic [31:0] Data_out;
    logic        Valid_out;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_pulses = 0;
    logic mem_mute = 1'b0;
    logic mon_en = 1'b0;

    logic [31:0] mem [0:63];
    logic [7:0]  exp_tx[$];
    logic [5:0]  exp_wr_addr[$];
    logic [31:0] exp_wr_data[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_tx = 8'h00;

    mem_cmd_ctrl #(.DATA_WIDTH(32), .MEM_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .write_En(write_En), .read_En(read_En), .Address(Address),
        .Data_in(Data_in), .Data_out(Data_out), .Valid_out(Valid_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: one-cycle read latency, Valid_out suppressible.
    always @(posedge clk) begin
        if (write_En) mem[Address] <= Data_in;
        Valid_out <= read_En && !mem_mute;
        Data_out  <= read_En ? mem[Address] : 32'h0;
    end

    // Output monitor: scoreboard pops, strobe exclusion, tx hold while stalled.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            check("wr_rd_excl", 64'(write_En & read_En), 64'd0);
            if (prev_stall && tx_valid) check("tx_hold", 64'(tx_data), 64'(prev_tx));
            if (write_En) begin
                wr_cnt++;
                if (exp_wr_addr.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    check("wr_addr", 64'(Address), 64'(exp_wr_addr.pop_front()));
                    check("wr_data", 64'(Data_in), 64'(exp_wr_data.pop_front()));
                end
            end
            if (read_En) rd_cnt++;
            if (err) err_pulses++;
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) check("tx_unexpected", 64'(tx_data), 64'hFFFF);
                else check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
        end
        prev_stall <= tx_valid && !tx_ready && !rst;
        prev_tx    <= tx_data;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] a, input logic [31:0] d);
        send_byte(8'h57);
        send_byte(a);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    endtask

    task automatic push_word(input logic [31:0] d);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || exp_tx.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 200), 64'd1);
    endtask

    initial begin
        int wr0;
        int rd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_txv", 64'(tx_valid), 64'd0);
        check("rst_strobes", 64'({write_En, read_En}), 64'd0);
        check("rst_addr", 64'(Address), 64'd0);
        check("rst_data", 64'(Data_in), 64'd0);
        check("rst_txd", 64'(tx_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Write DEADBEEF to address 5.
        exp_wr_addr.push_back(6'd5); exp_wr_data.push_back(32'hDEADBEEF);
        send_write(8'h05, 32'hDEADBEEF);
        @(negedge clk);
        check("busy_in_write", 64'(busy), 64'd1);
        @(negedge clk);
        check("busy_after_write", 64'(busy), 64'd0);
        check("wr_count1", 64'(wr_cnt), 64'd1);

        // Read it back with the transmitter always ready.
        rd0 = rd_cnt;
        push_word(32'hDEADBEEF);
        send_byte(8'h52); send_byte(8'h05);
        wait_idle("read1_done");
        check("rd_count1", 64'(rd_cnt - rd0), 64'd1);

        // Last address is writable; read back with a stalled transmitter
        // and a stray byte arriving mid-reply.
        exp_wr_addr.push_back(6'd63); exp_wr_data.push_back(32'h01234567);
        send_write(8'h3F, 32'h01234567);
        repeat (2) @(negedge clk);
        check("wr_count2", 64'(wr_cnt), 64'd2);
        tx_ready = 1'b0;
        push_word(32'h01234567);
        send_byte(8'h52); send_byte(8'h3F);
        for (int b = 0; b < 4; b++) begin
            if (b == 0) begin
                repeat (3) @(posedge clk); #1;
                rx_data = 8'h57; rx_valid = 1'b1;
                @(posedge clk); #1;
                rx_valid = 1'b0;
                @(negedge clk);
                check("stray_err", 64'(err), 64'd1);
                check("stray_busy", 64'(busy), 64'd1);
                repeat (6) @(posedge clk);
            end else begin
                repeat (10) @(posedge clk);
            end
            #1 tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
        end
        wait_idle("read2_done");
        tx_ready = 1'b1;

        // Bad opcode, then bad address after a valid write opcode.
        wr0 = wr_cnt; rd0 = rd_cnt;
        send_byte(8'h33);
        @(negedge clk);
        check("badop_err", 64'(err), 64'd1);
        check("badop_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("badop_err_pulse", 64'(err), 64'd0);
        send_byte(8'h57); send_byte(8'h40);
        @(negedge clk);
        check("badaddr_err", 64'(err), 64'd1);
        check("badaddr_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("bad_no_access", 64'({wr_cnt - wr0, rd_cnt - rd0}), 64'd0);

        // Read timeout: err exactly four cycles after WAIT_RD entry.
        mem_mute = 1'b1;
        send_byte(8'h52); send_byte(8'h05);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check("tmo_err", 64'(err), 64'(k == 5));
        end
        check("tmo_idle", 64'(busy), 64'd0);
        mem_mute = 1'b0;

        // Reset after the third data byte aborts the frame.
        wr0 = wr_cnt;
        send_byte(8'h57); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_write", 64'(wr_cnt - wr0), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // A full frame after the abort executes normally.
        exp_wr_addr.push_back(6'd7); exp_wr_data.push_back(32'hCAFEBABE);
        send_write(8'h07, 32'hCAFEBABE);
        repeat (2) @(negedge clk);
        check("post_rst_write", 64'(wr_cnt - wr0), 64'd1);
        push_word(32'hCAFEBABE);
        send_byte(8'h52); send_byte(8'h07);
        wait_idle("read3_done");

        repeat (3) @(negedge clk);
        check("wr_queue_empty", 64'(exp_wr_addr.size()), 64'd0);
        check("err_total", 64'(err_pulses), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
